// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: MEM-stage and backing-memory signals of data_mem_ctrl; slave = controller, master = pipeline/memory side
interface data_mem_ctrl_if;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_out;
  logic        stall;
  logic        bk_req;
  logic        bk_we;
  logic [29:0] bk_addr;
  logic [31:0] bk_wdata;
  logic        bk_ack;
  logic [31:0] bk_rdata;
  modport slave (
    input  data_addr, data_in, mem_read, mem_write, bk_ack, bk_rdata,
    output data_out, stall, bk_req, bk_we, bk_addr, bk_wdata
  );
  modport master (
    output data_addr, data_in, mem_read, mem_write, bk_ack, bk_rdata,
    input  data_out, stall, bk_req, bk_we, bk_addr, bk_wdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory controller with a DEPTH-entry store buffer and load forwarding; ports clk, reset, bus (data_mem_ctrl_if.slave)
module data_mem_ctrl #(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  data_mem_ctrl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, LDONE} state_t;
  state_t        state;
  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, idx;
  logic [CW-1:0] count;
  logic [31:0]   load_reg, hit_data;
  logic          req_q, we_q, hit, load, store, enq, pop, miss;
  logic [29:0]   baddr_q;
  logic [31:0]   wdata_q;
  logic          unused;
  assign unused = &{1'b0, bus.data_addr[1:0]};
  assign store  = bus.mem_write;
  assign load   = bus.mem_read && !bus.mem_write;
  assign enq    = store && count != CW'(DEPTH);
  assign pop    = state == DRAIN && bus.bk_ack;
  assign miss   = load && !hit && state != LDONE;
  // Later (younger) matches overwrite earlier ones while walking head to tail.
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count && addr_q[idx] == bus.data_addr[31:2]) begin
        hit = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end
  assign bus.stall    = (store && count == CW'(DEPTH)) || miss;
  assign bus.data_out = (state == LDONE && load) ? load_reg : (load && hit) ? hit_data : '0;
  assign bus.bk_req   = req_q;
  assign bus.bk_we    = we_q;
  assign bus.bk_addr  = baddr_q;
  assign bus.bk_wdata = wdata_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      load_reg <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      baddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      if (enq) begin
        addr_q[wr_ptr] <= bus.data_addr[31:2];
        data_q[wr_ptr] <= bus.data_in;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq) - CW'(pop);
      case (state)
        IDLE:
          if (miss) begin
            state   <= LOAD;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            baddr_q <= bus.data_addr[31:2];
          end else if (count != '0) begin
            state   <= DRAIN;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            baddr_q <= addr_q[rd_ptr];
            wdata_q <= data_q[rd_ptr];
          end
        DRAIN:
          if (bus.bk_ack) begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        LOAD:
          if (bus.bk_ack) begin
            state    <= LDONE;
            req_q    <= 1'b0;
            load_reg <= bus.bk_rdata;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int sc;
  always #5 clk = ~clk;
  data_mem_ctrl_if m();
  data_mem_ctrl #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(m.slave));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    m.mem_read = 1'b0;
    m.mem_write = 1'b0;
    m.data_addr = '0;
    m.data_in = '0;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    m.mem_read = 1'b0;
    m.mem_write = 1'b1;
    m.data_addr = a;
    m.data_in = d;
  endtask
  task automatic load(input logic [31:0] a);
    m.mem_read = 1'b1;
    m.mem_write = 1'b0;
    m.data_addr = a;
    m.data_in = '0;
  endtask
  task automatic ack_drain(input logic [29:0] a, input logic [31:0] d);
    int n = 0;
    while (!m.bk_req && n < 20) begin
      step;
      n++;
    end
    check("drain_req", 32'(m.bk_req), 1);
    check("drain_we", 32'(m.bk_we), 1);
    check("drain_addr", 32'(m.bk_addr), 32'(a));
    check("drain_wdata", m.bk_wdata, d);
    m.bk_ack = 1'b1;
    step;
    m.bk_ack = 1'b0;
    check("drain_req_drop", 32'(m.bk_req), 0);
  endtask
  initial begin
    idle_in;
    m.bk_ack = 1'b0;
    m.bk_rdata = '0;
    step;
    step;
    #1;
    check("rst_stall", 32'(m.stall), 0);
    check("rst_bk_req", 32'(m.bk_req), 0);
    check("rst_bk_we", 32'(m.bk_we), 0);
    check("rst_bk_addr", 32'(m.bk_addr), 0);
    check("rst_bk_wdata", m.bk_wdata, 0);
    check("rst_data_out", m.data_out, 0);
    reset = 1'b0;
    step;
    store(32'h100, 32'hDEADBEEF);
    #1 check("fwd_st_stall", 32'(m.stall), 0);
    step;
    load(32'h100);
    #1 check("fwd_data", m.data_out, 32'hDEADBEEF);
    check("fwd_stall", 32'(m.stall), 0);
    step;
    idle_in;
    check("fwd_no_read_req", 32'(m.bk_we), 1);
    ack_drain(30'h40, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      store(32'h10 + 32'(4 * i), 32'h1000 + 32'(i));
      #1 check("fill_stall", 32'(m.stall), 0);
      step;
    end
    store(32'h20, 32'h1004);
    #1 check("full_stall", 32'(m.stall), 1);
    check("full_head", 32'(m.bk_addr), 32'h4);
    m.bk_ack = 1'b1;
    #1 check("full_stall_pop", 32'(m.stall), 1);
    step;
    m.bk_ack = 1'b0;
    #1 check("full_lift", 32'(m.stall), 0);
    step;
    idle_in;
    for (int j = 1; j < 5; j++) ack_drain(30'((32'h10 + 32'(4 * j)) >> 2), 32'h1000 + 32'(j));
    store(32'h200, 32'd1);
    step;
    store(32'h200, 32'd2);
    step;
    load(32'h200);
    #1 check("young_data", m.data_out, 32'd2);
    check("young_stall", 32'(m.stall), 0);
    step;
    idle_in;
    ack_drain(30'h80, 32'd1);
    ack_drain(30'h80, 32'd2);
    load(32'h40);
    #1 check("miss_stall", 32'(m.stall), 1);
    check("miss_data", m.data_out, 0);
    sc = int'(m.stall);
    step;
    check("miss_req", 32'(m.bk_req), 1);
    check("miss_we", 32'(m.bk_we), 0);
    check("miss_addr", 32'(m.bk_addr), 32'h10);
    sc += int'(m.stall);
    step;
    sc += int'(m.stall);
    step;
    m.bk_ack = 1'b1;
    m.bk_rdata = 32'h12345678;
    #1 sc += int'(m.stall);
    step;
    m.bk_ack = 1'b0;
    #1 check("miss_stall_cycles", 32'(sc), 4);
    check("ldone_stall", 32'(m.stall), 0);
    check("ldone_data", m.data_out, 32'h12345678);
    check("ldone_req", 32'(m.bk_req), 0);
    step;
    idle_in;
    #1 check("noread_data", m.data_out, 0);
    store(32'h300, 32'hAA);
    step;
    idle_in;
    step;
    load(32'h400);
    #1 check("dl_stall", 32'(m.stall), 1);
    check("dl_we_first", 32'(m.bk_we), 1);
    step;
    ack_drain(30'hC0, 32'hAA);
    #1 check("dl_idle_stall", 32'(m.stall), 1);
    step;
    check("dl_req", 32'(m.bk_req), 1);
    check("dl_we", 32'(m.bk_we), 0);
    check("dl_addr", 32'(m.bk_addr), 32'h100);
    m.bk_ack = 1'b1;
    m.bk_rdata = 32'hCAFEF00D;
    step;
    m.bk_ack = 1'b0;
    #1 check("dl_data", m.data_out, 32'hCAFEF00D);
    check("dl_done_stall", 32'(m.stall), 0);
    step;
    idle_in;
    store(32'h500, 32'h5);
    step;
    store(32'h504, 32'h6);
    step;
    store(32'h508, 32'h7);
    step;
    idle_in;
    #1 check("rd_req", 32'(m.bk_req), 1);
    check("rd_count", 32'(dut.count), 3);
    reset = 1'b1;
    step;
    reset = 1'b0;
    #1 check("rd_req_drop", 32'(m.bk_req), 0);
    check("rd_count_clr", 32'(dut.count), 0);
    m.bk_ack = 1'b1;
    step;
    m.bk_ack = 1'b0;
    #1 check("rd_ack_req", 32'(m.bk_req), 0);
    check("rd_ack_count", 32'(dut.count), 0);
    load(32'h500);
    #1 check("rd_discard", 32'(m.stall), 1);
    step;
    check("rd_load_we", 32'(m.bk_we), 0);
    check("rd_load_addr", 32'(m.bk_addr), 32'h140);
    idle_in;
    reset = 1'b1;
    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
